// File: rtl/sequence_player.sv
// sequence_player: plays a stored colour pattern on four LEDs, timing each lit and dark interval with an external timer
module sequence_player #(
    parameter int DEPTH_W = 4,
    parameter int COLOR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_we,
    input  logic [DEPTH_W-1:0] load_addr,
    input  logic [COLOR_W-1:0] load_data,
    input  logic [DEPTH_W:0]   length,
    input  logic               play,
    output logic               start_clock,
    input  logic               clock_done,
    output logic [3:0]         led,
    output logic [DEPTH_W-1:0] step,
    output logic               busy,
    output logic               done
);
    localparam int STEPS = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] MAX_LEN = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] ONE = {{DEPTH_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, ON_R, ON_A, ON_W, OFF_R, OFF_A, OFF_W, FIN
    } state_t;

    state_t             state;
    logic [COLOR_W-1:0] mem [STEPS];
    logic [DEPTH_W:0]   len_q;
    logic [DEPTH_W:0]   eff_len;
    logic [DEPTH_W-1:0] step_nxt;
    logic               last;

    // Clamp the requested length and precompute the next step and end-of-pattern test
    always_comb begin
        eff_len  = (length > MAX_LEN) ? MAX_LEN : length;
        step_nxt = step + 1'b1;
        last     = ({1'b0, step} == len_q - ONE);
    end

    // Pattern register file; writes are locked out while a pattern is playing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) mem[i] <= '0;
        end else if (load_we && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    // Playback sequencer; every output is set on the transition into the state that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            len_q       <= '0;
            step        <= '0;
            led         <= '0;
            start_clock <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (play && eff_len != '0) begin
                    state       <= ON_R;
                    len_q       <= eff_len;
                    step        <= '0;
                    led         <= 4'b0001 << mem[0];
                    start_clock <= 1'b0;
                    busy        <= 1'b1;
                end
                ON_R: begin
                    state       <= ON_A;
                    start_clock <= 1'b1;
                end
                ON_A: state <= ON_W;
                ON_W: if (clock_done) begin
                    state       <= OFF_R;
                    led         <= '0;
                    start_clock <= 1'b0;
                end
                OFF_R: begin
                    state       <= OFF_A;
                    start_clock <= 1'b1;
                end
                OFF_A: state <= OFF_W;
                OFF_W: if (clock_done) begin
                    start_clock <= 1'b0;
                    if (last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= ON_R;
                        step  <= step_nxt;
                        led   <= 4'b0001 << mem[step_nxt];
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    led         <= '0;
                    start_clock <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: randomized scoreboard bench for sequence_player with a behavioural timer stub
module tb_sequence_player;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_we = 1'b0;
    logic [3:0] load_addr = '0;
    logic [1:0] load_data = '0;
    logic [4:0] length = '0;
    logic       play = 1'b0;
    logic       start_clock;
    logic       clock_done;
    logic [3:0] led;
    logic [3:0] step;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] led;
        logic [3:0] step;
        logic       sc;
        logic       done;
    } rec_t;

    rec_t q[$];
    int   mdl[16];
    int   tw = 5;
    logic stale = 1'b0;
    int   cnt = 0;

    sequence_player dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .length(length), .play(play),
        .start_clock(start_clock), .clock_done(clock_done), .led(led),
        .step(step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Timer stub: counts cycles with start_clock high, restarts on any low cycle
    always @(posedge clk) cnt <= start_clock ? cnt + 1 : 0;
    assign clock_done = (cnt >= tw) || (stale && cnt == 0);

    // Monitor: every busy cycle must match the next expected record; idle outputs must be quiet
    always @(negedge clk) begin
        if (rst) begin
            if (busy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_unexpected: busy=1 led=%b step=%0d with nothing expected", led, step);
                end else begin
                    rec_t e;
                    e = q.pop_front();
                    if (led !== e.led || step !== e.step || start_clock !== e.sc || done !== e.done) begin
                        errors++;
                        $display("FAIL play_cycle: got led=%b step=%0d sc=%b done=%b, want led=%b step=%0d sc=%b done=%b",
                                 led, step, start_clock, done, e.led, e.step, e.sc, e.done);
                    end
                end
            end else begin
                checks++;
                if (led !== 4'b0 || done !== 1'b0 || start_clock !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got led=%b done=%b sc=%b, want all 0", led, done, start_clock);
                end
            end
        end
    end

    function automatic logic [3:0] onehot(int c);
        int v;
        v = 1 << c;
        return v[3:0];
    endfunction

    // Reference: each step is a lit then a dark phase of 2+W cycles, timer restarted in the first
    task automatic expect_play(int len);
        int eff;
        rec_t r;
        eff = (len > 16) ? 16 : len;
        for (int s = 0; s < eff; s++) begin
            for (int ph = 0; ph < 2; ph++) begin
                for (int k = 0; k < 2 + tw; k++) begin
                    r.led  = (ph == 0) ? onehot(mdl[s]) : 4'b0;
                    r.step = 4'(s);
                    r.sc   = (k != 0);
                    r.done = 1'b0;
                    q.push_back(r);
                end
            end
        end
        if (eff > 0) begin
            r.led = 4'b0; r.step = 4'(eff - 1); r.sc = 1'b0; r.done = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic load(int a, int d);
        @(negedge clk);
        load_we = 1'b1; load_addr = 4'(a); load_data = 2'(d);
        @(negedge clk);
        load_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic start(int len);
        @(negedge clk);
        length = 5'(len); play = 1'b1;
        expect_play(len);
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (q.size() != 0 || busy) begin
            errors++;
            $display("FAIL playback_end: busy=%b with %0d expected cycles left, want idle and 0", busy, q.size());
        end
    endtask

    task automatic wait_step1_dark();
        int n;
        n = 0;
        while (!(busy && step == 4'd1 && led == 4'b0 && start_clock) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL reach_step1: step=%0d led=%b, want step 1 dark", step, led);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({led, step, busy, done, start_clock} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: led=%b step=%0d busy=%b done=%b sc=%b, want 0", led, step, busy, done, start_clock);
        end
        rst = 1'b1;
        load(0, 2); load(1, 0); load(2, 3);
        checks++;
        if (led !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: led=%b busy=%b, want 0 0", led, busy);
        end

        tw = 5;
        start(3);
        wait_idle();

        start(0);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_busy: busy=%b, want 0", busy);
        end

        for (int i = 0; i < 16; i++) load(i, $urandom_range(0, 3));
        tw = $urandom_range(2, 4);
        start(20);
        wait_idle();
        checks++;
        if (step !== 4'd15) begin
            errors++;
            $display("FAIL clamp_step: step=%0d, want 15", step);
        end

        load(1, 0);
        tw = 3;
        start(3);
        wait_step1_dark();
        @(negedge clk);
        play = 1'b1; length = 5'd5; load_we = 1'b1; load_addr = 4'd1; load_data = 2'd1;
        @(negedge clk);
        play = 1'b0; load_we = 1'b0;
        wait_idle();
        start(2);
        wait_idle();

        stale = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) load(i, $urandom_range(0, 3));
            tw = $urandom_range(2, 6);
            start($urandom_range(1, 5));
            wait_idle();
        end
        stale = 1'b0;

        for (int t = 0; t < 6; t++) begin
            load($urandom_range(0, 15), $urandom_range(0, 3));
            tw = $urandom_range(2, 5);
            start($urandom_range(0, 20));
            wait_idle();
        end

        tw = 4;
        start(3);
        wait_step1_dark();
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        q.delete();
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        checks++;
        if ({led, step, busy, done, start_clock} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset: led=%b step=%0d busy=%b done=%b sc=%b, want 0", led, step, busy, done, start_clock);
        end
        @(negedge clk);
        rst = 1'b1;
        start(1);
        @(negedge clk); #1;
        checks++;
        if (led !== 4'b0001) begin
            errors++;
            $display("FAIL cleared_mem: led=%b, want 0001", led);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
